// File: rtl/sal_dfi_dram_rsp.sv
// DFI-side DDR2 responder: decodes commands on the DFI control channel,
// tracks per-bank open rows, stores write bursts and returns read bursts
// at a fixed latency. Protocol violations raise sticky error bits.
module sal_dfi_dram_rsp #(
  parameter int BA_W      = 2,
  parameter int ROW_W     = 14,
  parameter int COL_W     = 10,
  parameter int MEM_ROW_W = 4,
  parameter int DATA_W    = 64,
  parameter int BURST     = 2,
  parameter int WL        = 2,
  parameter int RL        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dfi_cs_n,
  input  logic                  dfi_ras_n,
  input  logic                  dfi_cas_n,
  input  logic                  dfi_we_n,
  input  logic [BA_W-1:0]       dfi_bank,
  input  logic [ROW_W-1:0]      dfi_address,
  input  logic                  dfi_wrdata_en,
  input  logic [DATA_W-1:0]     dfi_wrdata,
  input  logic [DATA_W/8-1:0]   dfi_wrdata_mask,
  output logic                  dfi_rddata_valid,
  output logic [DATA_W-1:0]     dfi_rddata,
  output logic [5:0]            err_o,
  output logic [(1<<BA_W)-1:0]  bank_open_o
);

  localparam int NB    = 1 << BA_W;
  localparam int IDX_W = BA_W + MEM_ROW_W + COL_W;
  localparam int DEPTH = 1 << IDX_W;
  localparam int BYTES = DATA_W / 8;
  // Schedule depth covers the furthest beat of either burst type so the
  // read/write bus-window cross checks never index past the end.
  localparam int D     = ((RL > WL) ? RL : WL) + BURST;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS
  } cmd_e;

  // One scheduled beat: slot j of a schedule refers to the cycle j ahead of now.
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } slot_t;

  cmd_e              cmd;
  logic [NB-1:0]     bank_open_q, open_d;
  logic [ROW_W-1:0]  row_q [NB];
  logic              act_ok;
  logic [5:0]        err_q, err_set;
  logic [COL_W-1:0]  col_base;
  logic              rd_hit, wr_hit, bus_hit;
  logic [IDX_W-1:0]  new_idx [BURST];

  // Read slots are fetch cycles (one ahead of valid); write slots are data cycles.
  slot_t             rd_q [D];
  slot_t             rd_want [D];
  slot_t             wr_q [D];
  slot_t             wr_want [D];

  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // Decode the DDR2 command presented this cycle.
  always_comb begin
    cmd = CMD_NOP;
    if (!dfi_cs_n) begin
      case ({dfi_ras_n, dfi_cas_n, dfi_we_n})
        3'b011:  cmd = CMD_ACT;
        3'b101:  cmd = CMD_RD;
        3'b100:  cmd = CMD_WR;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_MRS;
        default: cmd = CMD_NOP;
      endcase
    end
  end

  // Bank state update, error detection and insertion of new bursts.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rd_want  = rd_q;
    wr_want  = wr_q;
    open_d   = bank_open_q;
    act_ok   = 1'b0;
    err_set  = '0;
    rd_hit   = 1'b0;
    wr_hit   = 1'b0;
    bus_hit  = 1'b0;
    // Column aligned down to a burst boundary; beat n fills the low bits.
    col_base = dfi_address[COL_W-1:0] & ~COL_W'(BURST - 1);
    for (int n = 0; n < BURST; n++)
      new_idx[n] = {dfi_bank, row_q[dfi_bank][MEM_ROW_W-1:0], col_base | COL_W'(n)};

    case (cmd)
      CMD_ACT: begin
        if (bank_open_q[dfi_bank]) err_set[0] = 1'b1;
        else begin
          open_d[dfi_bank] = 1'b1;
          act_ok           = 1'b1;
        end
      end
      CMD_PRE: begin
        if (dfi_address[10]) open_d = '0;
        else                 open_d[dfi_bank] = 1'b0;
      end
      CMD_REF: begin
        if (|bank_open_q) err_set[1] = 1'b1;
      end
      CMD_RD: begin
        if (!bank_open_q[dfi_bank]) err_set[2] = 1'b1;
        else begin
          // Read beat n is fetched at offset RL-1+n and on the bus at RL+n.
          for (int n = 0; n < BURST; n++) begin
            rd_hit  = rd_hit  | rd_q[RL-1+n].vld;
            bus_hit = bus_hit | wr_q[RL+n].vld;
          end
          err_set[4] = rd_hit;
          err_set[5] = bus_hit;
          if (!rd_hit && !bus_hit)
            for (int n = 0; n < BURST; n++) rd_want[RL-1+n] = '{vld: 1'b1, idx: new_idx[n]};
        end
      end
      CMD_WR: begin
        if (!bank_open_q[dfi_bank]) err_set[2] = 1'b1;
        else begin
          // Write beat n is on the bus at WL+n; a read beat on the bus then was fetched at WL+n-1.
          for (int n = 0; n < BURST; n++) begin
            wr_hit  = wr_hit  | wr_q[WL+n].vld;
            bus_hit = bus_hit | rd_q[WL+n-1].vld;
          end
          err_set[4] = wr_hit;
          err_set[5] = bus_hit;
          if (!wr_hit && !bus_hit)
            for (int n = 0; n < BURST; n++) wr_want[WL+n] = '{vld: 1'b1, idx: new_idx[n]};
        end
      end
      default: ;
    endcase

    // A write beat expected without strobe, or a strobe without an expected beat.
    if (wr_q[0].vld != dfi_wrdata_en) err_set[3] = 1'b1;
  end

  // Control state, schedules and the registered read data path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_open_q <= '0;
      err_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      for (int i = 0; i < NB; i++) row_q[i] <= '0;
      for (int j = 0; j < D; j++) begin
        rd_q[j] <= '0;
        wr_q[j] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      bank_open_q <= open_d;
      err_q       <= err_q | err_set;
      if (act_ok) row_q[dfi_bank] <= dfi_address;
      for (int j = 0; j < D - 1; j++) begin
        rd_q[j] <= rd_want[j+1];
        wr_q[j] <= wr_want[j+1];
      end
      rd_q[D-1]  <= '0;
      wr_q[D-1]  <= '0;
      rd_valid_q <= rd_want[0].vld;
      // Fetch reads the pre-edge array, so a write on the same edge is not forwarded.
      rd_data_q  <= rd_want[0].vld ? mem[rd_want[0].idx] : '0;
    end
  end

  // Commit unmasked bytes of the expected write beat.
  // NOTE: the storage array has no reset; its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_q[0].vld && dfi_wrdata_en)
      for (int b = 0; b < BYTES; b++)
        if (!dfi_wrdata_mask[b]) mem[wr_q[0].idx][b*8 +: 8] <= dfi_wrdata[b*8 +: 8];
  end

  assign dfi_rddata_valid = rd_valid_q;
  assign dfi_rddata       = rd_data_q;
  assign err_o            = err_q;
  assign bank_open_o      = bank_open_q;

endmodule

// File: tb/tb_sal_dfi_dram_rsp.sv
// Self-checking bench for sal_dfi_dram_rsp: scripted DFI command sequences
// with a scoreboard of expected read beats and a reference storage model.
module tb_sal_dfi_dram_rsp;

  localparam int WL = 2;
  localparam int RL = 4;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [1:0]  dfi_bank;
  logic [13:0] dfi_address;
  logic        dfi_wrdata_en;
  logic [63:0] dfi_wrdata;
  logic [7:0]  dfi_wrdata_mask;
  logic        dfi_rddata_valid;
  logic [63:0] dfi_rddata;
  logic [5:0]  err_o;
  logic [3:0]  bank_open_o;

  sal_dfi_dram_rsp dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dfi_cs_n         (dfi_cs_n),
    .dfi_ras_n        (dfi_ras_n),
    .dfi_cas_n        (dfi_cas_n),
    .dfi_we_n         (dfi_we_n),
    .dfi_bank         (dfi_bank),
    .dfi_address      (dfi_address),
    .dfi_wrdata_en    (dfi_wrdata_en),
    .dfi_wrdata       (dfi_wrdata),
    .dfi_wrdata_mask  (dfi_wrdata_mask),
    .dfi_rddata_valid (dfi_rddata_valid),
    .dfi_rddata       (dfi_rddata),
    .err_o            (err_o),
    .bank_open_o      (bank_open_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic [7:0]  mask;
  } wbeat_t;

  exp_t        sb [$];
  wbeat_t      wq [$];
  logic [63:0] mm [int];
  logic [13:0] tb_row [4];
  logic [5:0]  exp_err;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int mem_idx(input logic [1:0] b, input logic [13:0] row,
                                 input logic [9:0] col, input int n);
    logic [15:0] i;
    i = {b, row[3:0], (col & 10'h3FE) | 10'(n)};
    return int'(i);
  endfunction

  // Advance one cycle: return command to NOP, drive any scheduled write beat,
  // then compare the read channel against the scoreboard.
  task automatic tick();
    bit   exp_v;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} = 4'b1111;
    dfi_wrdata_en   = 1'b0;
    dfi_wrdata      = '0;
    dfi_wrdata_mask = '0;
    for (int i = 0; i < wq.size(); i++) begin
      if (wq[i].cyc == cyc) begin
        dfi_wrdata_en   = 1'b1;
        dfi_wrdata      = wq[i].data;
        dfi_wrdata_mask = wq[i].mask;
        wq.delete(i);
        break;
      end
    end
    exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
    if (dfi_rddata_valid || exp_v) begin
      check("rd_valid", 64'(dfi_rddata_valid), 64'(exp_v));
      if (exp_v) begin
        e = sb.pop_front();
        if (dfi_rddata_valid) check("rd_data", dfi_rddata, e.data);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic cmd(input logic [3:0] c, input logic [1:0] b, input logic [13:0] a);
    {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} = c;
    dfi_bank    = b;
    dfi_address = a;
    tick();
  endtask

  task automatic act(input logic [1:0] b, input logic [13:0] row);
    tb_row[b] = row;
    cmd(C_ACT, b, row);
  endtask

  // ok: the bench expects the WR to be accepted; en: which beats get a strobe.
  task automatic issue_wr(input logic [1:0] b, input logic [9:0] col,
                          input logic [63:0] d0, input logic [63:0] d1,
                          input logic [7:0] m0, input logic [7:0] m1,
                          input logic [1:0] en, input bit ok);
    logic [63:0] d [2];
    logic [7:0]  m [2];
    logic [63:0] v;
    int          i;
    d[0] = d0; d[1] = d1; m[0] = m0; m[1] = m1;
    if (ok) begin
      for (int n = 0; n < 2; n++) begin
        if (en[n]) begin
          wq.push_back('{cyc: cyc + WL + n, data: d[n], mask: m[n]});
          i = mem_idx(b, tb_row[b], col, n);
          v = mm.exists(i) ? mm[i] : 64'h0;
          for (int k = 0; k < 8; k++)
            if (!m[n][k]) v[k*8 +: 8] = d[n][k*8 +: 8];
          mm[i] = v;
        end
      end
    end
    cmd(C_WR, b, {4'h0, col});
  endtask

  task automatic issue_rd(input logic [1:0] b, input logic [9:0] col, input bit ok);
    int i;
    if (ok) begin
      for (int n = 0; n < 2; n++) begin
        i = mem_idx(b, tb_row[b], col, n);
        sb.push_back('{cyc: cyc + RL + n, data: (mm.exists(i) ? mm[i] : 64'h0)});
      end
    end
    cmd(C_RD, b, {4'h0, col});
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() > 0 || wq.size() > 0) && k < 40) begin
      tick();
      k++;
    end
    if (sb.size() > 0 || wq.size() > 0) check("drain_timeout", 64'(sb.size() + wq.size()), 64'h0);
    idle(2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    wq.delete();
    exp_err = '0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    rst_n = 1'b0;
    {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} = 4'b1111;
    dfi_bank = '0; dfi_address = '0;
    dfi_wrdata_en = 1'b0; dfi_wrdata = '0; dfi_wrdata_mask = '0;
    exp_err = '0;
    for (int i = 0; i < 4; i++) tb_row[i] = '0;
    idle(3);
    check("rst_valid", 64'(dfi_rddata_valid), 64'h0);
    check("rst_rddata", dfi_rddata, 64'h0);
    check("rst_err", 64'(err_o), 64'h0);
    check("rst_bank_open", 64'(bank_open_o), 64'h0);
    rst_n = 1'b1;
    idle(2);

    // Basic write then read on bank 1.
    act(2'd1, 14'h0005);
    check("act_open", 64'(bank_open_o), 64'h2);
    issue_wr(2'd1, 10'h010, 64'hAAAA_AAAA_AAAA_AAA1, 64'hAAAA_AAAA_AAAA_AAA2, 8'h00, 8'h00, 2'b11, 1'b1);
    drain();
    issue_rd(2'd1, 10'h010, 1'b1);
    drain();
    check("basic_err", 64'(err_o), 64'(exp_err));

    // Masked write over an all-ones location.
    issue_wr(2'd1, 10'h020, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 8'h00, 2'b11, 1'b1);
    drain();
    issue_wr(2'd1, 10'h020, 64'h1234_5678_9ABC_DEF0, 64'h0BAD_F00D_0000_0001, 8'h0F, 8'h00, 2'b11, 1'b1);
    drain();
    issue_rd(2'd1, 10'h020, 1'b1);
    drain();
    check("mask_model", mm[mem_idx(2'd1, 14'h0005, 10'h020, 0)], 64'h1234_5678_FFFF_FFFF);

    // Reads two cycles apart form one contiguous stream; one apart collides.
    issue_rd(2'd1, 10'h010, 1'b1);
    idle(1);
    issue_rd(2'd1, 10'h020, 1'b1);
    drain();
    check("b2b_err", 64'(err_o), 64'(exp_err));
    issue_rd(2'd1, 10'h010, 1'b1);
    issue_rd(2'd1, 10'h020, 1'b0);
    exp_err[4] = 1'b1;
    drain();
    check("rd_overlap_err", 64'(err_o), 64'(exp_err));

    // Idle-bank read, double activate, refresh with an open bank.
    do_reset();
    issue_rd(2'd2, 10'h000, 1'b0);
    exp_err[2] = 1'b1;
    idle(8);
    act(2'd0, 14'h0001);
    act(2'd0, 14'h0002);
    exp_err[0] = 1'b1;
    cmd(C_REF, 2'd0, 14'h0000);
    exp_err[1] = 1'b1;
    idle(2);
    check("cmd_err", 64'(err_o), 64'(exp_err));

    // Missing write strobe keeps the old data on that beat.
    do_reset();
    act(2'd1, 14'h0005);
    issue_wr(2'd1, 10'h010, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666, 8'h00, 8'h00, 2'b10, 1'b1);
    exp_err[3] = 1'b1;
    drain();
    issue_rd(2'd1, 10'h010, 1'b1);
    drain();
    check("miss_en_err", 64'(err_o), 64'(exp_err));

    // Stray write strobe with no WR outstanding.
    do_reset();
    wq.push_back('{cyc: cyc + 1, data: 64'hDEAD_BEEF_DEAD_BEEF, mask: 8'h00});
    idle(3);
    exp_err[3] = 1'b1;
    check("stray_en_err", 64'(err_o), 64'(exp_err));

    // Overlapping write bursts, then read/write bus collision.
    do_reset();
    act(2'd3, 14'h0007);
    issue_wr(2'd3, 10'h040, 64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202, 8'h00, 8'h00, 2'b11, 1'b1);
    issue_wr(2'd3, 10'h042, 64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404, 8'h00, 8'h00, 2'b11, 1'b0);
    exp_err[4] = 1'b1;
    drain();
    check("wr_overlap_err", 64'(err_o), 64'(exp_err));
    issue_rd(2'd3, 10'h040, 1'b1);
    idle(1);
    issue_wr(2'd3, 10'h042, 64'h0505_0505_0505_0505, 64'h0606_0606_0606_0606, 8'h00, 8'h00, 2'b11, 1'b0);
    exp_err[5] = 1'b1;
    drain();
    check("bus_err", 64'(err_o), 64'(exp_err));
    issue_rd(2'd3, 10'h042, 1'b1);
    drain();

    // Precharge-all closes every bank.
    do_reset();
    for (int b = 0; b < 4; b++) act(2'(b), 14'(b + 8));
    check("all_open", 64'(bank_open_o), 64'hF);
    cmd(C_PRE, 2'd0, 14'h0400);
    check("pre_all", 64'(bank_open_o), 64'h0);
    act(2'd2, 14'h0009);
    cmd(C_PRE, 2'd2, 14'h0000);
    check("pre_one", 64'(bank_open_o), 64'h0);
    check("pre_err", 64'(err_o), 64'(exp_err));

    // Reset in the middle of a read burst.
    do_reset();
    act(2'd1, 14'h0005);
    issue_rd(2'd1, 10'h010, 1'b1);
    idle(RL - 1);
    check("mid_valid_up", 64'(dfi_rddata_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    check("mid_valid_drop", 64'(dfi_rddata_valid), 64'h0);
    check("mid_rddata", dfi_rddata, 64'h0);
    check("mid_err", 64'(err_o), 64'h0);
    sb.delete();
    wq.delete();
    idle(2);
    rst_n = 1'b1;
    idle(4);
    check("post_rst_open", 64'(bank_open_o), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
